// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg
// Shared definitions for the XOR cipher datapath: FSM state encoding,
// the default word width and the helper that sizes the bit counters.
package xor_cipher_pkg;

  localparam int DATA_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Plain constants with the same encoding, for code that carries the state
  // as a bare logic vector.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Counter width able to hold the value DATA_SIZE itself.
  function automatic int cnt_w(input int data_size);
    return $clog2(data_size) + 1;
  endfunction

endpackage

// File: rtl/xor_serializer_piso_shifter.sv
// piso_shifter
// Parallel-in / serial-out shift register. A load captures the whole word;
// a shift moves it one place toward the MSB, filling with zero. The serial
// output is always the current MSB.
// Ports:
//   iClk    clock, rising edge
//   iRst    asynchronous active-low reset (clears the register)
//   iLoad   parallel load (has priority over iShift)
//   iShift  shift left by one
//   iData   parallel word to load
//   oMsb    current MSB of the register
module piso_shifter #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iLoad,
  input  logic                 iShift,
  input  logic [DATA_SIZE-1:0] iData,
  output logic                 oMsb
);

  logic [DATA_SIZE-1:0] sreg_q;
  logic [DATA_SIZE-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (iLoad) begin
      sreg_d = iData;
    end else if (iShift) begin
      sreg_d = {sreg_q[DATA_SIZE-2:0], 1'b0};
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign oMsb = sreg_q[DATA_SIZE-1];

endmodule

// File: rtl/xor_serializer.sv
// xor_serializer
// Waits for a complete upstream word, XORs it with the key and shifts the
// result out MSB first, one bit per enabled clock.
// Handshake: oValid is high exactly in the cycles where oData_out carries a
// ciphertext bit; there is no back-pressure other than iEn, which stalls the
// shift for the cycle it is low.
// Ports:
//   iClk, iRst        clock and asynchronous active-low reset
//   iEn               shift enable
//   iLoading          upstream still shifting bits in
//   iData, iKey       plaintext word and key (sampled only in LATCH)
//   iBit_counter      upstream bit count, word complete at DATA_SIZE
//   oData_out         serial ciphertext bit
//   oValid            oData_out is a real bit this cycle
//   oBusy             high in LATCH, SHIFT and DONE
//   oDone             one-cycle pulse after the last bit
//   oBit_counter      bits already emitted in the current word
//   oState            current FSM state (debug visibility)
module xor_serializer
  import xor_cipher_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  localparam int CNT_W = cnt_w(DATA_SIZE)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iLoading,
  input  logic [DATA_SIZE-1:0] iData,
  input  logic [CNT_W-1:0]     iBit_counter,
  input  logic [DATA_SIZE-1:0] iKey,
  output logic                 oData_out,
  output logic                 oValid,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [CNT_W-1:0]     oBit_counter,
  output logic [1:0]           oState
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             start;
  logic             word_full;
  logic             load;
  logic             shift;
  logic             msb;

  assign word_full = (iBit_counter == CNT_W'(DATA_SIZE));
  assign start     = word_full && !iLoading && armed_q;
  assign load      = (state_q == ST_LATCH);
  assign shift     = (state_q == ST_SHIFT) && iEn;

  // armed guards against encrypting the same upstream word twice: it is
  // consumed by any start condition (even one ignored outside IDLE) and only
  // restored once upstream shows it is working on a new word.
  always_comb begin
    armed_d = armed_q;
    if (iLoading || !word_full) begin
      armed_d = 1'b1;
    end
    if (start) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (iEn) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_SIZE - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  piso_shifter #(
    .DATA_SIZE(DATA_SIZE)
  ) u_shifter (
    .iClk  (iClk),
    .iRst  (iRst),
    .iLoad (load),
    .iShift(shift),
    .iData (iData ^ iKey),
    .oMsb  (msb)
  );

  // All status decoded from registered state; only oValid sees iEn.
  assign oData_out    = (state_q == ST_SHIFT) && msb;
  assign oValid       = (state_q == ST_SHIFT) && iEn;
  assign oBusy        = (state_q != ST_IDLE);
  assign oDone        = (state_q == ST_DONE);
  assign oBit_counter = cnt_q;
  assign oState       = state_q;

endmodule

// File: tb/tb_xor_serializer.sv
module tb_xor_serializer;

  localparam int DS = 32;
  localparam int CW = 6;

  logic          iClk;
  logic          iRst;
  logic          iEn;
  logic          iLoading;
  logic [DS-1:0] iData;
  logic [CW-1:0] iBit_counter;
  logic [DS-1:0] iKey;
  logic          oData_out;
  logic          oValid;
  logic          oBusy;
  logic          oDone;
  logic [CW-1:0] oBit_counter;
  logic [1:0]    oState;

  int total = 0;
  int bad   = 0;

  // observations gathered by drive_word
  logic [DS-1:0] got;
  int            first_k, done_k, done_cnt, nbits, busy_gap;
  logic          busy_after;
  logic [CW-1:0] done_ctr;
  bit            timed_out, aborted;
  logic [3:0]    ab_out;
  logic [CW-1:0] ab_cnt;
  logic [1:0]    ab_state;
  logic [CW-1:0] stall_cnt_q[$];
  logic          stall_val_q[$];
  logic          stall_dat_q[$];

  xor_serializer #(.DATA_SIZE(DS)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iEn         (iEn),
    .iLoading    (iLoading),
    .iData       (iData),
    .iBit_counter(iBit_counter),
    .iKey        (iKey),
    .oData_out   (oData_out),
    .oValid      (oValid),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oBit_counter(oBit_counter),
    .oState      (oState)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Presents one word and follows it to completion. stall_at/mid_at/abort_at
  // are bit counts at which to stall, re-present a start, or reset (-1: off).
  task automatic drive_word(input logic [DS-1:0] d, input logic [DS-1:0] k,
                            input int stall_at, input int stall_len,
                            input int mid_at, input int abort_at);
    int stall_left;
    got = '0; first_k = -1; done_k = -1; done_cnt = 0; nbits = 0;
    busy_gap = 0; busy_after = 1'b1; done_ctr = '0; timed_out = 0; aborted = 0;
    stall_cnt_q.delete(); stall_val_q.delete(); stall_dat_q.delete();
    stall_left = stall_len;
    @(posedge iClk); #1;
    iEn = 1'b1; iLoading = 1'b1;
    iBit_counter = CW'($urandom_range(0, DS - 1));
    @(posedge iClk); #1;
    iLoading = 1'b0; iBit_counter = CW'(DS); iData = d; iKey = k;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(posedge iClk); #1;
      if (cyc == 2) begin
        iData = $urandom; iKey = $urandom;
      end
      iLoading = 1'b0; iBit_counter = CW'(DS);
      if (mid_at >= 0 && nbits == mid_at && first_k >= 0) iLoading = 1'b1;
      iEn = !(stall_at >= 0 && nbits == stall_at && stall_left > 0);
      if (abort_at >= 0 && nbits == abort_at) begin
        iRst = 1'b0; iLoading = 1'b1; iBit_counter = '0; #1;
        ab_out = {oData_out, oValid, oBusy, oDone};
        ab_cnt = oBit_counter; ab_state = oState; aborted = 1;
        repeat (3) begin
          @(posedge iClk); #1;
          if (oDone) done_cnt++;
        end
        iRst = 1'b1;
        repeat (3) begin
          @(posedge iClk); #1;
          if (oDone) done_cnt++;
        end
        break;
      end
      #1;
      if (!iEn) begin
        stall_cnt_q.push_back(oBit_counter);
        stall_val_q.push_back(oValid);
        stall_dat_q.push_back(oData_out);
        stall_left--;
      end
      if (oValid) begin
        if (first_k < 0) first_k = cyc;
        got = {got[DS-2:0], oData_out};
        nbits++;
      end
      if (oDone) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = cyc; done_ctr = oBit_counter;
        end
      end
      if (done_k < 0 && !oBusy) busy_gap++;
      if (done_k >= 0 && cyc == done_k + 1) busy_after = oBusy;
      if (done_k >= 0 && cyc >= done_k + 2) break;
    end
    if (done_k < 0 && !aborted) timed_out = 1;
  endtask

  // Holds the start condition and counts cycles with oBusy high.
  task automatic watch_idle(input int n, output int busy_cycles);
    busy_cycles = 0;
    repeat (n) begin
      @(posedge iClk); #1;
      iEn = 1'b1; iLoading = 1'b0; iBit_counter = CW'(DS);
      #1;
      if (oBusy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    iRst = 1'b0; iEn = 1'b0; iLoading = 1'b1; iBit_counter = '0;
    iData = '0; iKey = '0;
    #3;
    total++;
    if ({oData_out, oValid, oBusy, oDone} !== 4'b0 || oBit_counter !== '0 || oState !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: got dat/val/busy/done=%b cnt=%0d st=%0d want 0000 0 0",
               {oData_out, oValid, oBusy, oDone}, oBit_counter, oState);
    end
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b1;
  endtask

  task automatic test_basic();
    logic [DS-1:0] exp;
    exp = 32'hDEADBEEF ^ 32'hA5A5A5A5;
    drive_word(32'hDEADBEEF, 32'hA5A5A5A5, -1, 0, -1, -1);
    total++;
    if (timed_out) begin bad++; $display("FAIL basic_timeout: no oDone within budget"); end
    total++;
    if (got !== 32'h7B081B4A || nbits != DS) begin
      bad++; $display("FAIL basic_stream: got %h (%0d bits) want 7b081b4a (32 bits)", got, nbits);
    end
    total++;
    if (got !== exp) begin bad++; $display("FAIL basic_model: got %h want %h", got, exp); end
    total++;
    if (first_k != 2) begin bad++; $display("FAIL basic_first_lat: got %0d want 2", first_k); end
    total++;
    if (done_k != DS + 2 || done_cnt != 1) begin
      bad++; $display("FAIL basic_done: cycle %0d count %0d want %0d 1", done_k, done_cnt, DS + 2);
    end
    total++;
    if (done_ctr !== CW'(DS)) begin bad++; $display("FAIL basic_cnt_at_done: got %0d want %0d", done_ctr, DS); end
    total++;
    if (busy_gap != 0 || busy_after !== 1'b0) begin
      bad++; $display("FAIL basic_busy: gaps %0d after_done %b want 0 0", busy_gap, busy_after);
    end
  endtask

  task automatic test_stall();
    logic [DS-1:0] exp;
    exp = 32'hDEADBEEF ^ 32'hA5A5A5A5;
    drive_word(32'hDEADBEEF, 32'hA5A5A5A5, 10, 3, -1, -1);
    total++;
    if (got !== exp || done_k != DS + 5 || done_cnt != 1 || timed_out) begin
      bad++; $display("FAIL stall_stream: got %h done@%0d want %h done@%0d", got, done_k, exp, DS + 5);
    end
    total++;
    if (stall_cnt_q.size() != 3) begin
      bad++; $display("FAIL stall_len: got %0d stall cycles want 3", stall_cnt_q.size());
    end
    foreach (stall_cnt_q[i]) begin
      total++;
      if (stall_cnt_q[i] !== CW'(10) || stall_val_q[i] !== 1'b0 || stall_dat_q[i] !== exp[DS-1-10]) begin
        bad++;
        $display("FAIL stall_hold[%0d]: cnt %0d val %b dat %b want 10 0 %b",
                 i, stall_cnt_q[i], stall_val_q[i], stall_dat_q[i], exp[DS-1-10]);
      end
    end
  endtask

  task automatic test_rearm();
    int busy_cycles;
    watch_idle(40, busy_cycles);
    total++;
    if (busy_cycles != 0) begin bad++; $display("FAIL rearm_no_repeat: busy %0d cycles want 0", busy_cycles); end
    drive_word(32'hCAFEF00D, 32'h0F0F1234, -1, 0, -1, -1);
    total++;
    if (got !== (32'hCAFEF00D ^ 32'h0F0F1234) || done_cnt != 1 || timed_out) begin
      bad++; $display("FAIL rearm_word: got %h want %h", got, 32'hCAFEF00D ^ 32'h0F0F1234);
    end
    watch_idle(40, busy_cycles);
    total++;
    if (busy_cycles != 0) begin bad++; $display("FAIL rearm_once: busy %0d cycles want 0", busy_cycles); end
  endtask

  task automatic test_zero_key();
    drive_word(32'h12345678, 32'h0, -1, 0, -1, -1);
    total++;
    if (got !== 32'h12345678 || timed_out) begin
      bad++; $display("FAIL zero_key: got %h want 12345678", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [DS-1:0] d, k;
    drive_word(32'h55AA33CC, 32'h1, -1, 0, -1, 17);
    total++;
    if (!aborted || ab_out !== 4'b0 || ab_cnt !== '0 || ab_state !== 2'd0) begin
      bad++; $display("FAIL reset_mid_outputs: dat/val/busy/done=%b cnt=%0d st=%0d want 0000 0 0",
                      ab_out, ab_cnt, ab_state);
    end
    total++;
    if (done_cnt != 0) begin bad++; $display("FAIL reset_mid_done: got %0d pulses want 0", done_cnt); end
    d = $urandom; k = $urandom;
    drive_word(d, k, -1, 0, -1, -1);
    total++;
    if (got !== (d ^ k) || first_k != 2 || done_k != DS + 2 || timed_out) begin
      bad++; $display("FAIL reset_mid_fresh: got %h first %0d done %0d want %h 2 %0d",
                      got, first_k, done_k, d ^ k, DS + 2);
    end
  endtask

  task automatic test_ignored_start();
    logic [DS-1:0] d, k;
    int busy_cycles;
    d = $urandom; k = $urandom;
    drive_word(d, k, -1, 0, 5, -1);
    total++;
    if (got !== (d ^ k) || done_cnt != 1 || done_k != DS + 2 || timed_out) begin
      bad++; $display("FAIL ignored_start_word: got %h done %0d want %h %0d", got, done_k, d ^ k, DS + 2);
    end
    watch_idle(40, busy_cycles);
    total++;
    if (busy_cycles != 0) begin bad++; $display("FAIL ignored_start_extra: busy %0d cycles want 0", busy_cycles); end
  endtask

  task automatic test_random();
    logic [DS-1:0] d, k;
    int sa, sl;
    for (int n = 0; n < 8; n++) begin
      d = $urandom; k = $urandom;
      sa = $urandom_range(0, DS - 1); sl = $urandom_range(0, 4);
      drive_word(d, k, sa, sl, -1, -1);
      total++;
      if (got !== (d ^ k) || done_k != DS + 2 + sl || done_cnt != 1 || timed_out) begin
        bad++; $display("FAIL random[%0d]: got %h done %0d want %h %0d", n, got, done_k, d ^ k, DS + 2 + sl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_rearm();
    test_zero_key();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_serializer.md
# xor_serializer

Downstream neighbour of the input deserializer in the XOR cipher datapath. It waits for a complete word (bit count equal to DATA_SIZE while loading has ended), XORs the word with the key, and shifts the result out serially, MSB first, one bit per enabled clock. It provides busy, valid and done status to the top-level pin logic.

## Interface
- DATA_SIZE, 32, word width in bits; must be ≥ 2
- CNT_W, $clog2(DATA_SIZE)+1, width of the bit counters (derived; not overridden)
- iClk  input  1  system clock, rising-edge
- iRst  input  1  asynchronous, active-low reset
- iEn  input  1  shift enable; a low value stalls the shift
- iLoading  input  1  high while the upstream stage is still shifting bits in
- iData  input  DATA_SIZE  parallel plaintext word from upstream
- iBit_counter  input  CNT_W  upstream bit count; word is complete at the value DATA_SIZE
- iKey  input  DATA_SIZE  cipher key; sampled only in LATCH
- oData_out  output  1  serial ciphertext bit
- oValid  output  1  oData_out holds a real bit this cycle
- oBusy  output  1  high in LATCH, SHIFT and DONE
- oDone  output  1  one-cycle pulse after the last bit
- oBit_counter  output  CNT_W  number of bits already emitted in the current word

## Operation
- FSM states: IDLE, LATCH, SHIFT, DONE.
- start condition = (iBit_counter == DATA_SIZE) && !iLoading && armed.
- IDLE → LATCH on the start condition. Clear armed.
- LATCH: sreg <= iData ^ iKey; oBit_counter <= 0. Always go to SHIFT next cycle, regardless of iEn.
- SHIFT:
  - oData_out = sreg[DATA_SIZE-1].
  - oValid = iEn.
  - On a clock with iEn=1: shift sreg left, filling with 0, and increment oBit_counter.
  - When the bit being emitted is number DATA_SIZE-1 and iEn=1, go to DONE. oBit_counter then reads DATA_SIZE.
- DONE: oDone=1 for exactly one cycle, then IDLE. oBit_counter holds DATA_SIZE until the next LATCH.
- armed is set again when iLoading=1 or iBit_counter != DATA_SIZE. It can be set in any state. This prevents a second encryption of the same upstream word.
- iData and iKey changing outside LATCH have no effect.
- A start condition outside IDLE is ignored. armed stays clear, so that word is dropped; upstream must wait for oBusy=0.
- All XOR is bitwise at full DATA_SIZE width. There is no truncation or extension.

## Timing
- Reset values (async, while iRst=0): state=IDLE, sreg=0, armed=1, oData_out=0, oValid=0, oBusy=0, oDone=0, oBit_counter=0.
- Reset asserted mid-SHIFT aborts the word immediately. No oDone is produced.
- Latency: start condition seen at edge N → LATCH during cycle N+1 → first valid bit during cycle N+2.
- With iEn held high, the last bit is in cycle N+1+DATA_SIZE and oDone is in cycle N+2+DATA_SIZE. oBusy is high from N+1 through N+2+DATA_SIZE.
- Each cycle with iEn=0 in SHIFT adds one cycle. During it, oValid=0 and oData_out and oBit_counter hold.
- oValid, oBusy and oDone are registered or decoded from registered state only. None has a combinational path from iEn except oValid, which is state-gated by iEn.
- Minimum IDLE-to-IDLE period is DATA_SIZE+3 cycles.

## Structure
- Shared package xor_cipher_pkg:
  - state enum (IDLE=2'd0, LATCH=2'd1, SHIFT=2'd2, DONE=2'd3)
  - DATA_SIZE default constant
  - CNT_W function
- Sub-module piso_shifter (DATA_SIZE): parallel load, shift-left on enable, MSB out, async active-low reset.
- The FSM, armed flag and counter stay in xor_serializer.

## Test plan
- Basic word: iData=0xDEADBEEF, iKey=0xA5A5A5A5, iEn=1. Assert iBit_counter=32 with iLoading=0. Required: serial stream 0x7B081B4A MSB first over 32 cycles, first bit 2 cycles after start, then oDone for 1 cycle, then oBusy low.
- Stall: same word with iEn low for 3 cycles after bit 10. Required: oValid=0 and oData_out/oBit_counter frozen (10) during the stall, same final stream, oDone 3 cycles later.
- Re-arm: hold iBit_counter=32 and iLoading=0 after oDone. Required: no second word. Pulse iLoading=1 for 1 cycle, then 32 again: exactly one new word.
- Zero key: iKey=0, iData=0x12345678. Required: output equals 0x12345678.
- Reset mid-shift: drop iRst at bit 17. Required: all outputs 0, state IDLE, no oDone; a fresh start after release works normally.
- Ignored start: present a start condition during SHIFT. Required: current word unaffected, no extra word afterwards.
